// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one DIMxDIM systolic matmul pass: clear, feed DIM columns,
// drain the skew/array pipeline with zero fill, then flag completion.
module systolic_seq_ctrl #(
    parameter int DIM   = 8,
    parameter int DRAIN = 3*DIM-1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   hold,
    output logic                   busy,
    output logic                   mac_clr,
    output logic                   fifo_en,
    output logic                   feed_valid,
    output logic [$clog2(DIM)-1:0] feed_addr,
    output logic                   done
);

    localparam int AW   = $clog2(DIM);
    localparam int MAXC = (DIM > DRAIN) ? DIM : DRAIN;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] FEED_LAST  = CW'(DIM - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A held cycle leaves state and counter untouched so the pass resumes in place.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    cnt_d   = '0;
                end
            end
            S_CLR: begin
                if (!hold) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
            end
            S_FEED: begin
                if (!hold) begin
                    if (cnt_q == FEED_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (!hold) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the registered state; only hold gates them combinationally.
    always_comb begin
        busy       = (state_q != S_IDLE);
        mac_clr    = (state_q == S_CLR) && !hold;
        fifo_en    = ((state_q == S_FEED) || (state_q == S_DRAIN)) && !hold;
        feed_valid = (state_q == S_FEED) && !hold;
        feed_addr  = (state_q == S_FEED) ? cnt_q[AW-1:0] : '0;
        done       = (state_q == S_DONE);
    end

endmodule
